// File: rtl/distance_pkg.sv
// Shared types and helpers for the distance-driven gain stage.
// Levels run 0 (far, silent) to MAX_LEVEL (closest, unity gain).
package distance_pkg;

    typedef logic [3:0] level_t;

    localparam int MAX_LEVEL = 8;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } slew_state_t;

    // Level 8 maps to 128, so a >>> 7 of the product gives bit-exact unity gain.
    function automatic logic [8:0] level_to_mult(input level_t level);
        return {1'b0, level, 4'b0000};
    endfunction

endpackage

// File: rtl/gain_slew.sv
// Turns the raw intensity level into a debounced, one-step-per-tick gain.
// The slew FSM state is exported for observation.
module gain_slew #(
    parameter int STEP_CYCLES = 40000,
    parameter int MAX_LEVEL   = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               i_intensity,
    output logic [3:0]               o_gain,
    output logic                     o_muted,
    output distance_pkg::slew_state_t o_state
);
    import distance_pkg::*;

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;
    level_t           w_level;
    level_t           r_candidate;
    logic             r_stable;
    level_t           r_target;
    level_t           r_gain;
    level_t           w_gain_nxt;
    logic             r_muted;
    slew_state_t      r_state;
    slew_state_t      w_state_nxt;

    assign w_tick  = (r_tick_cnt == CNT_W'(STEP_CYCLES - 1));
    assign w_level = (i_intensity > level_t'(MAX_LEVEL)) ? '0 : i_intensity;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // A new level must be seen on two further ticks before it becomes the target.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_candidate <= '0;
            r_stable    <= 1'b0;
            r_target    <= '0;
        end else if (w_tick) begin
            if (w_level == r_candidate) begin
                if (r_stable) begin
                    r_target <= r_candidate;
                end
                r_stable <= 1'b1;
            end else begin
                r_candidate <= w_level;
                r_stable    <= 1'b0;
            end
        end
    end

    // Steps are guarded by the live target so a mid-ramp change never overshoots.
    always_comb begin
        w_gain_nxt  = r_gain;
        w_state_nxt = r_state;
        case (r_state)
            UP: begin
                if (w_tick && (r_target > r_gain)) begin
                    w_gain_nxt = r_gain + 1'b1;
                end
            end
            DOWN: begin
                if (w_tick && (r_target < r_gain)) begin
                    w_gain_nxt = r_gain - 1'b1;
                end
            end
            default: w_gain_nxt = r_gain;
        endcase
        if (r_target > w_gain_nxt) begin
            w_state_nxt = UP;
        end else if (r_target < w_gain_nxt) begin
            w_state_nxt = DOWN;
        end else begin
            w_state_nxt = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= HOLD;
            r_gain  <= '0;
            r_muted <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
            r_muted <= (w_gain_nxt == '0);
        end
    end

    assign o_gain  = r_gain;
    assign o_muted = r_muted;
    assign o_state = r_state;

endmodule

// File: rtl/distance_gain.sv
// Scales a signed sample stream by the slew-limited distance gain.
// Valid/ready: a word moves when valid && ready; the whole 2-stage pipe advances only when the output slot is free or being taken.
module distance_gain #(
    parameter int SAMPLE_W    = 16,
    parameter int STEP_CYCLES = 40000,
    parameter int MAX_LEVEL   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [3:0]                    intensity,
    input  logic                          in_valid,
    input  logic signed [SAMPLE_W-1:0]    in_sample,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic signed [SAMPLE_W-1:0]    out_sample,
    input  logic                          out_ready,
    output logic [3:0]                    gain,
    output logic                          muted,
    output distance_pkg::slew_state_t     dbg_state
);
    import distance_pkg::*;

    localparam int PROD_W = SAMPLE_W + 9;

    logic                       w_en;
    logic                       r_a_valid;
    logic signed [SAMPLE_W-1:0] r_a_sample;
    logic [8:0]                 r_a_mult;
    logic signed [PROD_W-1:0]   w_product;
    logic                       r_out_valid;
    logic signed [SAMPLE_W-1:0] r_out_sample;

    gain_slew #(
        .STEP_CYCLES(STEP_CYCLES),
        .MAX_LEVEL  (MAX_LEVEL)
    ) u_slew (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_intensity(intensity),
        .o_gain     (gain),
        .o_muted    (muted),
        .o_state    (dbg_state)
    );

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    // Multiplier operand is zero-extended so it stays positive in the signed product.
    assign w_product = PROD_W'(r_a_sample) * $signed({{SAMPLE_W{1'b0}}, r_a_mult});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a_valid    <= 1'b0;
            r_a_sample   <= '0;
            r_a_mult     <= '0;
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
        end else if (w_en) begin
            r_a_valid <= in_valid;
            if (in_valid) begin
                r_a_sample <= in_sample;
                r_a_mult   <= level_to_mult(gain);
            end
            r_out_valid <= r_a_valid;
            if (r_a_valid) begin
                r_out_sample <= SAMPLE_W'(w_product >>> 7);
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_sample = r_out_sample;

endmodule

// File: tb/tb_distance_gain.sv
// Directed bench for distance_gain: multiply vector table plus ramp, debounce,
// reversal, stall and reset sequences, with a fast slew tick.
module tb_distance_gain;
    import distance_pkg::*;

    localparam int SAMPLE_W = 16;
    localparam int STEP     = 4;

    typedef struct {
        logic [3:0]         lvl;
        logic signed [15:0] s;
        logic signed [15:0] exp;
    } vec_t;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic [3:0]                 intensity;
    logic                       in_valid;
    logic signed [SAMPLE_W-1:0] in_sample;
    logic                       in_ready;
    logic                       out_valid;
    logic signed [SAMPLE_W-1:0] out_sample;
    logic                       out_ready;
    logic [3:0]                 gain;
    logic                       muted;
    slew_state_t                dbg_state;

    int                 n_checks = 0;
    int                 n_errors = 0;
    logic [15:0]        exp_q[$];
    vec_t               vecs[12];
    int                 cyc;
    int                 next_s;
    int                 got;
    logic               flag_a;
    logic               flag_b;
    logic [3:0]         peak;
    logic [3:0]         prev_g;
    logic signed [15:0] held;
    logic [15:0]        exp_w;

    distance_gain #(
        .SAMPLE_W   (SAMPLE_W),
        .STEP_CYCLES(STEP),
        .MAX_LEVEL  (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .intensity (intensity),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sample(out_sample),
        .out_ready (out_ready),
        .gain      (gain),
        .muted     (muted),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic signed [15:0] scale(input logic signed [15:0] s, input int lvl);
        int p;
        p = int'(s) * lvl * 16;
        return 16'(p >>> 7);
    endfunction

    // Driver tasks (all entered and left on a falling edge)
    task automatic wait_gain_change(output int cycles);
        logic [3:0] prev;
        prev   = gain;
        cycles = 0;
        while (gain == prev && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic set_gain(input logic [3:0] lvl);
        int n;
        n = 0;
        intensity = lvl;
        while (gain != lvl && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("set_gain", 32'(gain), 32'(lvl));
        repeat (2) @(negedge clk);
    endtask

    task automatic send_one(input string name, input logic signed [15:0] s,
                            input logic signed [15:0] exp);
        int lat;
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_sample = s;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd2);
        check({name, "_value"}, 32'(out_sample), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{4'd8, 16'sh4000,  16'sh4000};
        vecs[1]  = '{4'd8, -16'sd1,    -16'sd1};
        vecs[2]  = '{4'd8, 16'sh8000,  16'sh8000};
        vecs[3]  = '{4'd4, -16'sd3,    -16'sd2};
        vecs[4]  = '{4'd4, 16'sh7FFF,  16'sh3FFF};
        vecs[5]  = '{4'd4, 16'sh8000,  16'shC000};
        vecs[6]  = '{4'd4, 16'sd5,     16'sd2};
        vecs[7]  = '{4'd2, 16'sd100,   16'sd25};
        vecs[8]  = '{4'd2, -16'sd1,    -16'sd1};
        vecs[9]  = '{4'd1, 16'sd1000,  16'sd125};
        vecs[10] = '{4'd1, -16'sd7,    -16'sd1};
        vecs[11] = '{4'd0, 16'sh7FFF,  16'sd0};

        // Reset
        reset_n   = 1'b0;
        intensity = 4'd0;
        in_valid  = 1'b0;
        in_sample = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_gain", 32'(gain), 32'd0);
        check("rst_muted", 32'(muted), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sample", 32'(out_sample), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(HOLD));
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Full ramp 0 -> 8
        intensity = 4'd8;
        check("ramp_muted_start", 32'(muted), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            wait_gain_change(cyc);
            check($sformatf("ramp_gain%0d", k), 32'(gain), 32'(k));
            check($sformatf("ramp_muted%0d", k), 32'(muted), 32'd0);
            if (k == 1) check("ramp_debounce", 32'(cyc >= 2 * STEP), 32'd1);
            else        check($sformatf("ramp_period%0d", k), 32'(cyc), 32'(STEP));
        end
        repeat (3 * STEP) @(negedge clk);
        check("ramp_hold", 32'(gain), 32'd8);

        // Multiply vector table
        for (int i = 0; i < 12; i++) begin
            if (gain != vecs[i].lvl) set_gain(vecs[i].lvl);
            send_one($sformatf("mul%0d", i), vecs[i].s, vecs[i].exp);
        end

        // Out-of-range level is silence
        set_gain(4'd3);
        intensity = 4'd12;
        for (int k = 2; k >= 0; k--) begin
            wait_gain_change(cyc);
            check($sformatf("sanitize_gain%0d", k), 32'(gain), 32'(k));
        end
        check("sanitize_muted", 32'(muted), 32'd1);
        send_one("sanitize_out", 16'sh1234, 16'sd0);
        repeat (3 * STEP) @(negedge clk);
        check("sanitize_hold", 32'(gain), 32'd0);

        // Level toggling every tick never settles
        set_gain(4'd5);
        flag_a = 1'b0;
        for (int t = 0; t < 12; t++) begin
            intensity = (t % 2 == 1) ? 4'd0 : 4'd8;
            repeat (STEP) begin
                @(negedge clk);
                if (gain != 4'd5) flag_a = 1'b1;
            end
        end
        check("toggle_moved", 32'(flag_a), 32'd0);
        check("toggle_gain", 32'(gain), 32'd5);

        // Reversal mid-ramp
        set_gain(4'd1);
        intensity = 4'd6;
        cyc = 0;
        while (gain != 4'd4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rev_reach4", 32'(gain), 32'd4);
        intensity = 4'd2;
        peak   = gain;
        prev_g = gain;
        flag_a = 1'b0;
        flag_b = 1'b0;
        for (int c = 0; c < 25 * STEP; c++) begin
            @(negedge clk);
            if (gain > peak) peak = gain;
            if (gain < prev_g) flag_a = 1'b1;
            if (flag_a && gain > prev_g) flag_b = 1'b1;
            prev_g = gain;
        end
        check("rev_peak_le6", 32'(peak <= 4'd6), 32'd1);
        check("rev_went_down", 32'(flag_a), 32'd1);
        check("rev_no_rebound", 32'(flag_b), 32'd0);
        check("rev_final", 32'(gain), 32'd2);

        // Streaming through a 5-cycle output stall, scoreboarded
        set_gain(4'd8);
        exp_q.delete();
        next_s = 1;
        got    = 0;
        held   = '0;
        for (int c = 0; c < 80 && got < 20; c++) begin
            out_ready = !(c >= 6 && c < 11);
            in_valid  = (next_s <= 20);
            in_sample = 16'(next_s);
            #1;
            if (c >= 6 && c < 11) begin
                check($sformatf("stall_in_ready%0d", c), 32'(in_ready), 32'd0);
                check($sformatf("stall_out_valid%0d", c), 32'(out_valid), 32'd1);
                if (c == 6) held = out_sample;
                else check($sformatf("stall_hold%0d", c), 32'(out_sample), 32'(held));
            end
            if (out_valid && out_ready) begin
                check("stream_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                check($sformatf("stream_data%0d", got), 32'(out_sample), 32'(signed'(exp_w)));
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(scale(16'(next_s), 8));
                next_s++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stream_count", 32'(got), 32'd20);
        check("stream_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a stall
        repeat (2) @(negedge clk);
        in_valid  = 1'b1;
        in_sample = 16'sh0055;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_stall_valid", 32'(out_valid), 32'd1);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_stall_valid", 32'(out_valid), 32'd0);
        check("rst_stall_gain", 32'(gain), 32'd0);
        check("rst_stall_muted", 32'(muted), 32'd1);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_stall_ready", 32'(in_ready), 32'd1);
        flag_a = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) flag_a = 1'b1;
        end
        check("rst_no_leak", 32'(flag_a), 32'd0);

        // Report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
